can_tx_sequencer: RTL and testbench

CAN_TX_SEQUENCER -- requirements
Module: can_tx_sequencer

---
 rtl/can_tx_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_can_tx_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_sequencer.sv
// CAN transmit sequencer: configures the controller, loads a 13-byte frame,
// requests transmission and polls status until done, timeout or bus-off.
module can_tx_sequencer #(
  parameter logic [7:0]  BTR0    = 8'hC4,
  parameter logic [7:0]  BTR1    = 8'h3E,
  parameter logic [7:0]  FD_BTR0 = 8'hC4,
  parameter logic [7:0]  FD_BTR1 = 8'h02,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         frame_valid_i,
  output logic         frame_ready_o,
  input  logic [103:0] frame_data_i,
  output logic         reg_we_o,
  output logic         reg_re_o,
  output logic [7:0]   reg_addr_write_o,
  output logic [7:0]   reg_addr_read_o,
  output logic [31:0]  reg_data_o,
  input  logic [31:0]  reg_data_i,
  output logic         tx_we_o,
  output logic [3:0]   tx_addr_o,
  output logic [7:0]   tx_data_o,
  input  logic         bus_off_i,
  output logic         cfg_done_o,
  output logic         tx_done_o,
  output logic         tx_err_o
);

  typedef enum logic [2:0] {
    S_CFG, S_READY, S_LOAD, S_CMD, S_WAIT, S_ABORT
  } state_t;

  state_t         state, state_nx;
  logic [3:0]     cnt, cnt_nx;
  logic [15:0]    polls, polls_nx;
  logic [103:0]   frame_q;
  logic [103:0]   frame_sh;
  logic           done_q, done_nx;
  logic           cap;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_CFG;
      cnt     <= '0;
      polls   <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      polls  <= polls_nx;
      done_q <= done_nx;
      if (cap) frame_q <= frame_data_i;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    polls_nx = polls;
    done_nx  = 1'b0;
    cap      = 1'b0;
    unique case (state)
      S_CFG: begin
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'd11) begin
          state_nx = S_READY;
          cnt_nx   = '0;
        end
      end
      S_READY: begin
        if (frame_valid_i) begin
          state_nx = S_LOAD;
          cnt_nx   = '0;
          cap      = 1'b1;
        end
      end
      S_LOAD: begin
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'd12) begin
          state_nx = S_CMD;
          cnt_nx   = '0;
        end
      end
      S_CMD: begin
        state_nx = S_WAIT;
        cnt_nx   = '0;
        polls_nx = '0;
      end
      S_WAIT: begin
        if (!cnt[0]) begin
          polls_nx = polls + 16'd1;
          cnt_nx   = 4'd1;
        end else begin
          cnt_nx = '0;
          if (reg_data_i[3]) begin
            done_nx  = 1'b1;
            state_nx = S_READY;
          end else if (polls >= TIMEOUT) begin
            state_nx = S_ABORT;
          end
        end
      end
      S_ABORT: state_nx = S_READY;
      default: state_nx = S_CFG;
    endcase
    // Bus-off overrides everything, including a completion seen this cycle.
    if (state != S_CFG && bus_off_i) begin
      state_nx = S_CFG;
      cnt_nx   = '0;
      done_nx  = 1'b0;
      cap      = 1'b0;
    end
  end

  assign frame_sh = frame_q >> {cnt, 3'b000};

  always_comb begin
    reg_we_o         = 1'b0;
    reg_re_o         = 1'b0;
    reg_addr_write_o = '0;
    reg_addr_read_o  = '0;
    reg_data_o       = '0;
    tx_we_o          = 1'b0;
    tx_addr_o        = '0;
    tx_data_o        = '0;
    frame_ready_o    = 1'b0;
    cfg_done_o       = 1'b0;
    tx_done_o        = 1'b0;
    tx_err_o         = 1'b0;
    if (!rst_i) begin
      cfg_done_o = (state != S_CFG);
      tx_done_o  = done_q;
      unique case (state)
        S_CFG: begin
          if (!cnt[0]) begin
            reg_we_o = 1'b1;
            case (cnt[3:1])
              3'd0: begin
                reg_addr_write_o = 8'd0;
                reg_data_o       = 32'h01;
              end
              3'd1: begin
                reg_addr_write_o = 8'd6;
                reg_data_o       = {24'h0, BTR0};
              end
              3'd2: begin
                reg_addr_write_o = 8'd7;
                reg_data_o       = {24'h0, BTR1};
              end
              3'd3: begin
                reg_addr_write_o = 8'd25;
                reg_data_o       = {24'h0, FD_BTR0};
              end
              3'd4: begin
                reg_addr_write_o = 8'd26;
                reg_data_o       = {24'h0, FD_BTR1};
              end
              default: begin
                reg_addr_write_o = 8'd0;
                reg_data_o       = 32'h00;
              end
            endcase
          end
        end
        S_READY: frame_ready_o = !bus_off_i;
        S_LOAD: begin
          tx_we_o   = 1'b1;
          tx_addr_o = cnt;
          tx_data_o = frame_sh[7:0];
          tx_err_o  = bus_off_i;
        end
        S_CMD: begin
          reg_we_o         = 1'b1;
          reg_addr_write_o = 8'd1;
          reg_data_o       = 32'h01;
          tx_err_o         = bus_off_i;
        end
        S_WAIT: begin
          tx_err_o = bus_off_i;
          if (!cnt[0]) begin
            reg_re_o        = 1'b1;
            reg_addr_read_o = 8'd2;
          end
        end
        S_ABORT: begin
          reg_we_o         = 1'b1;
          reg_addr_write_o = 8'd1;
          reg_data_o       = 32'h02;
          tx_err_o         = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_sequencer.sv
// Directed bench for can_tx_sequencer: config, transmit, timeout,
// bus-off and reset scenarios with immediate assertions.
module tb_can_tx_sequencer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         frame_valid_i;
  logic         frame_ready_o;
  logic [103:0] frame_data_i;
  logic         reg_we_o;
  logic         reg_re_o;
  logic [7:0]   reg_addr_write_o;
  logic [7:0]   reg_addr_read_o;
  logic [31:0]  reg_data_o;
  logic [31:0]  reg_data_i;
  logic         tx_we_o;
  logic [3:0]   tx_addr_o;
  logic [7:0]   tx_data_o;
  logic         bus_off_i;
  logic         cfg_done_o;
  logic         tx_done_o;
  logic         tx_err_o;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err = 0;

  logic [7:0] ca [6] = '{8'd0, 8'd6, 8'd7, 8'd25, 8'd26, 8'd0};
  logic [7:0] cd [6] = '{8'h01, 8'hC4, 8'h3E, 8'hC4, 8'h02, 8'h00};

  can_tx_sequencer #(.TIMEOUT(16'd4)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .frame_valid_i(frame_valid_i),
    .frame_ready_o(frame_ready_o),
    .frame_data_i(frame_data_i),
    .reg_we_o(reg_we_o),
    .reg_re_o(reg_re_o),
    .reg_addr_write_o(reg_addr_write_o),
    .reg_addr_read_o(reg_addr_read_o),
    .reg_data_o(reg_data_o),
    .reg_data_i(reg_data_i),
    .tx_we_o(tx_we_o),
    .tx_addr_o(tx_addr_o),
    .tx_data_o(tx_data_o),
    .bus_off_i(bus_off_i),
    .cfg_done_o(cfg_done_o),
    .tx_done_o(tx_done_o),
    .tx_err_o(tx_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (tx_done_o) n_done++;
    if (tx_err_o) n_err++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cfg();
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0)
        chk("cfg_wr", {cfg_done_o, reg_we_o, reg_addr_write_o, reg_data_o},
            {1'b0, 1'b1, ca[i/2], 24'h0, cd[i/2]});
      else
        chk("cfg_idle", {cfg_done_o, reg_we_o, reg_re_o, tx_we_o}, 4'b0000);
      tick();
    end
    chk("cfg_exit", {cfg_done_o, frame_ready_o}, 2'b11);
  endtask

  task automatic send_frame();
    for (int k = 0; k < 13; k++) frame_data_i[8*k +: 8] = 8'(k);
    frame_valid_i = 1'b1;
    #1;
    chk("accept_rdy", frame_ready_o, 1'b1);
    tick();
    frame_valid_i = 1'b0;
    frame_data_i = {104{1'b1}};
  endtask

  function automatic logic [66:0] all_out();
    return {reg_we_o, reg_re_o, tx_we_o, frame_ready_o, cfg_done_o,
            tx_done_o, tx_err_o, reg_addr_write_o, reg_addr_read_o,
            reg_data_o, tx_addr_o, tx_data_o};
  endfunction

  initial begin
    int nre;
    int d0;
    int e0;
    logic seen;
    rst_i = 1'b1;
    frame_valid_i = 1'b0;
    frame_data_i = '0;
    reg_data_i = '0;
    bus_off_i = 1'b0;
    tick();
    tick();
    chk("reset_outs", all_out(), '0);

    // Configuration after reset
    rst_i = 1'b0;
    #1;
    run_cfg();

    // Normal transmit, completion on 3rd poll
    send_frame();
    #1;
    for (int k = 0; k < 13; k++) begin
      chk("load", {tx_we_o, reg_we_o, reg_re_o, tx_addr_o, tx_data_o},
          {3'b100, 4'(k), 8'(k)});
      tick();
    end
    chk("cmd", {reg_we_o, reg_addr_write_o, reg_data_o}, {1'b1, 8'd1, 32'h1});
    tick();
    for (int p = 1; p <= 3; p++) begin
      chk("poll", {reg_re_o, reg_addr_read_o, reg_we_o}, {1'b1, 8'd2, 1'b0});
      tick();
      reg_data_i = (p == 3) ? 32'h08 : 32'h00;
      #1;
      chk("poll_gap", {reg_re_o, tx_done_o}, 2'b00);
      tick();
      reg_data_i = '0;
    end
    chk("done_pulse", {tx_done_o, tx_err_o, frame_ready_o}, 3'b101);
    tick();
    chk("done_once", {tx_done_o, n_done}, {1'b0, 32'd1});

    // Timeout: status stays 0
    e0 = n_err;
    send_frame();
    repeat (14) tick();
    nre = 0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (reg_re_o) nre++;
      if (reg_we_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_wr", {seen, reg_addr_write_o, reg_data_o, tx_err_o},
        {1'b1, 8'd1, 32'h2, 1'b1});
    chk("timeout_polls", nre, 4);
    tick();
    chk("abort_ready", {frame_ready_o, 32'(n_err - e0)}, {1'b1, 32'd1});

    // Bus-off during LOAD at address 5
    e0 = n_err;
    send_frame();
    repeat (5) tick();
    bus_off_i = 1'b1;
    #1;
    chk("busoff_load", {tx_err_o, tx_addr_o}, {1'b1, 4'd5});
    tick();
    bus_off_i = 1'b0;
    #1;
    run_cfg();
    chk("busoff_err_cnt", n_err - e0, 1);

    // Bus-off together with completion status
    d0 = n_done;
    e0 = n_err;
    send_frame();
    repeat (15) tick();
    reg_data_i = 32'h08;
    bus_off_i = 1'b1;
    #1;
    chk("busoff_wait_err", tx_err_o, 1'b1);
    tick();
    bus_off_i = 1'b0;
    reg_data_i = '0;
    #1;
    chk("busoff_no_done", tx_done_o, 1'b0);
    run_cfg();
    chk("busoff_cnts", {32'(n_done - d0), 32'(n_err - e0)}, {32'd0, 32'd1});

    // Reset during WAIT
    d0 = n_done;
    e0 = n_err;
    send_frame();
    repeat (15) tick();
    reg_data_i = 32'h08;
    rst_i = 1'b1;
    #1;
    chk("rst_wait_outs", all_out(), '0);
    tick();
    rst_i = 1'b0;
    reg_data_i = '0;
    #1;
    run_cfg();
    tick();
    chk("rst_cnts", {32'(n_done - d0), 32'(n_err - e0)}, {32'd0, 32'd0});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
